// File: rtl/framebuffer_write_arbiter_if.sv
// rtl/framebuffer_write_arbiter_if.sv - requester and RAM-side signal bundle for the framebuffer write arbiter
interface framebuffer_write_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  logic                  req0;
  logic                  req1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] data0;
  logic [DATA_WIDTH-1:0] data1;
  logic                  last0;
  logic                  last1;
  logic                  ack0;
  logic                  ack1;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_data_out;
  logic                  ram_write_enable;
  logic                  ram_clk_enable;
  logic [1:0]            owner;

  modport master (
    output req0, req1, addr0, addr1, data0, data1, last0, last1,
    input  ack0, ack1, ram_address, ram_data_out, ram_write_enable, ram_clk_enable, owner
  );

  modport slave (
    input  req0, req1, addr0, addr1, data0, data1, last0, last1,
    output ack0, ack1, ram_address, ram_data_out, ram_write_enable, ram_clk_enable, owner
  );
endinterface

// File: rtl/framebuffer_write_arbiter.sv
// rtl/framebuffer_write_arbiter.sv - round-robin burst arbiter sharing framebuffer write port A
module framebuffer_write_arbiter #(
  parameter int ADDR_WIDTH      = 12,
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_BURST       = 64,
  parameter int BURST_CNT_WIDTH = 7
) (
  input  logic clk_in,
  input  logic reset,
  framebuffer_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam logic [BURST_CNT_WIDTH:0] CAP = (BURST_CNT_WIDTH+1)'(MAX_BURST);

  state_t                 state;
  logic                   rr_next;
  logic [BURST_CNT_WIDTH-1:0] beat_cnt;

  logic                   own_req;
  logic                   own_last;
  logic [ADDR_WIDTH-1:0]  own_addr;
  logic [DATA_WIDTH-1:0]  own_data;
  logic                   other_req;
  logic                   accept;
  logic [BURST_CNT_WIDTH:0] cnt_sum;
  logic                   cap_hit;
  logic                   release_now;

  always_comb begin
    own_req   = 1'b0;
    own_last  = 1'b0;
    own_addr  = '0;
    own_data  = '0;
    other_req = 1'b0;
    case (state)
      OWN0: begin
        own_req   = bus.req0;
        own_last  = bus.last0;
        own_addr  = bus.addr0;
        own_data  = bus.data0;
        other_req = bus.req1;
      end
      OWN1: begin
        own_req   = bus.req1;
        own_last  = bus.last1;
        own_addr  = bus.addr1;
        own_data  = bus.data1;
        other_req = bus.req0;
      end
      default: ;
    endcase
    accept  = own_req;
    cnt_sum = {1'b0, beat_cnt} + {{BURST_CNT_WIDTH{1'b0}}, accept};
    // >= rather than == so a saturated owner still yields once the other side shows up
    cap_hit     = (cnt_sum >= CAP);
    release_now = (accept && own_last) || !own_req || (cap_hit && other_req);
  end

  assign bus.ack0 = (state == OWN0) && bus.req0;
  assign bus.ack1 = (state == OWN1) && bus.req1;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      rr_next              <= 1'b0;
      beat_cnt             <= '0;
      bus.owner            <= 2'b00;
      bus.ram_address      <= '0;
      bus.ram_data_out     <= '0;
      bus.ram_write_enable <= 1'b0;
      bus.ram_clk_enable   <= 1'b0;
    end else begin
      bus.ram_write_enable <= accept;
      bus.ram_clk_enable   <= accept;
      if (accept) begin
        bus.ram_address  <= own_addr;
        bus.ram_data_out <= own_data;
      end

      case (state)
        IDLE: begin
          if (bus.req0 && (!bus.req1 || !rr_next)) begin
            state     <= OWN0;
            bus.owner <= OWN0;
            beat_cnt  <= '0;
          end else if (bus.req1) begin
            state     <= OWN1;
            bus.owner <= OWN1;
            beat_cnt  <= '0;
          end
        end
        OWN0, OWN1: begin
          if (release_now) begin
            rr_next <= (state == OWN0);
            if (other_req) begin
              state     <= (state == OWN0) ? OWN1 : OWN0;
              bus.owner <= (state == OWN0) ? OWN1 : OWN0;
              beat_cnt  <= '0;
            end else begin
              state     <= IDLE;
              bus.owner <= IDLE;
            end
          end else begin
            beat_cnt <= cap_hit ? CAP[BURST_CNT_WIDTH-1:0] : cnt_sum[BURST_CNT_WIDTH-1:0];
          end
        end
        default: begin
          state     <= IDLE;
          bus.owner <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
// tb/tb_framebuffer_write_arbiter.sv - scoreboard bench for the framebuffer write arbiter
module tb_framebuffer_write_arbiter;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
    logic        last;
  } beat_t;

  logic clk;
  logic rst;
  int   checks;
  int   passed;

  beat_t       q0[$];
  beat_t       q1[$];
  logic [19:0] sb[$];
  int          got_order[$];
  int          exp_order[$];
  int          start0;
  int          start1;
  int          wr_first;
  int          wr_last;
  int          writes;

  framebuffer_write_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) bus();

  framebuffer_write_arbiter #(
    .ADDR_WIDTH(12), .DATA_WIDTH(8), .MAX_BURST(4), .BURST_CNT_WIDTH(7)
  ) dut (
    .clk_in(clk),
    .reset(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push_burst(input int id, input int n, input int base_a, input int base_d, input bit with_last);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.addr = 12'(base_a + i);
      b.data = 8'(base_d + i);
      b.last = with_last && (i == n - 1);
      if (id == 0) q0.push_back(b); else q1.push_back(b);
      exp_order.push_back(id);
    end
  endtask

  task automatic drive_inputs(input int cyc);
    bus.req0 = (q0.size() > 0) && (cyc >= start0);
    bus.addr0 = (q0.size() > 0) ? q0[0].addr : 12'h000;
    bus.data0 = (q0.size() > 0) ? q0[0].data : 8'h00;
    bus.last0 = (q0.size() > 0) ? q0[0].last : 1'b0;
    bus.req1 = (q1.size() > 0) && (cyc >= start1);
    bus.addr1 = (q1.size() > 0) ? q1[0].addr : 12'h000;
    bus.data1 = (q1.size() > 0) ? q1[0].data : 8'h00;
    bus.last1 = (q1.size() > 0) ? q1[0].last : 1'b0;
  endtask

  task automatic run_traffic(input string name, input int budget, input int stop_writes);
    int cyc;
    logic [19:0] e;
    cyc = 0;
    got_order.delete();
    wr_first = -1;
    wr_last = -1;
    writes = 0;
    @(posedge clk);
    #1;
    forever begin
      drive_inputs(cyc);
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.ram_write_enable !== 1'b1) $display("FAIL %s write_strobe got=%b want=1", name, bus.ram_write_enable);
        else passed++;
        checks++;
        if ({bus.ram_address, bus.ram_data_out} !== e || bus.ram_clk_enable !== 1'b1)
          $display("FAIL %s write_beat got=%h/%h ce=%b want=%h/%h ce=1", name,
                   bus.ram_address, bus.ram_data_out, bus.ram_clk_enable, e[19:8], e[7:0]);
        else passed++;
      end else if (bus.ram_write_enable !== 1'b0) begin
        checks++;
        $display("FAIL %s spurious_write got=%b want=0", name, bus.ram_write_enable);
      end
      if (bus.ram_write_enable === 1'b1) begin
        if (wr_first < 0) wr_first = cyc;
        wr_last = cyc;
        writes++;
      end
      if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1) begin
        checks++;
        $display("FAIL %s dual_ack got=11 want=one-hot", name);
      end
      if (bus.ack0 === 1'b1) begin
        checks++;
        if (bus.owner !== 2'b01) $display("FAIL %s owner_at_ack0 got=%b want=01", name, bus.owner);
        else passed++;
        sb.push_back({bus.addr0, bus.data0});
        got_order.push_back(0);
        void'(q0.pop_front());
      end else if (bus.ack1 === 1'b1) begin
        checks++;
        if (bus.owner !== 2'b10) $display("FAIL %s owner_at_ack1 got=%b want=10", name, bus.owner);
        else passed++;
        sb.push_back({bus.addr1, bus.data1});
        got_order.push_back(1);
        void'(q1.pop_front());
      end
      if (stop_writes > 0 && writes >= stop_writes) break;
      if (q0.size() == 0 && q1.size() == 0 && sb.size() == 0) break;
      cyc++;
      if (cyc >= budget) begin
        checks++;
        $display("FAIL %s timeout got=%0d cycles want<%0d", name, cyc, budget);
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_order(input string name);
    checks++;
    if (got_order.size() !== exp_order.size())
      $display("FAIL %s order_len got=%0d want=%0d", name, got_order.size(), exp_order.size());
    else passed++;
    for (int i = 0; i < exp_order.size() && i < got_order.size(); i++) begin
      checks++;
      if (got_order[i] !== exp_order[i])
        $display("FAIL %s order[%0d] got=%0d want=%0d", name, i, got_order[i], exp_order[i]);
      else passed++;
    end
    exp_order.delete();
  endtask

  task automatic check_span(input string name, input int want);
    checks++;
    if (wr_last - wr_first !== want)
      $display("FAIL %s write_span got=%0d want=%0d", name, wr_last - wr_first, want);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req0 = 1'b1;
    bus.addr0 = 12'h055;
    bus.data0 = 8'h5A;
    bus.last0 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.ack0 !== 1'b0 || bus.ram_write_enable !== 1'b0 || bus.owner !== 2'b00 || bus.ram_address !== 12'h000)
      $display("FAIL reset_hold got ack0=%b we=%b owner=%b addr=%h want 0/0/00/000",
               bus.ack0, bus.ram_write_enable, bus.owner, bus.ram_address);
    else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ack0 !== 1'b0) $display("FAIL reset_cycle1_ack got=%b want=0", bus.ack0);
    else passed++;
    @(negedge clk);
    checks++;
    if (bus.ack0 !== 1'b1 || bus.owner !== 2'b01)
      $display("FAIL reset_cycle2_ack got ack0=%b owner=%b want 1/01", bus.ack0, bus.owner);
    else passed++;
    @(posedge clk);
    #1 bus.req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ram_write_enable !== 1'b1 || bus.ram_address !== 12'h055 || bus.ram_data_out !== 8'h5A || bus.owner !== 2'b00)
      $display("FAIL reset_cycle3_write got we=%b addr=%h data=%h owner=%b want 1/055/5a/00",
               bus.ram_write_enable, bus.ram_address, bus.ram_data_out, bus.owner);
    else passed++;
  endtask

  task automatic test_burst4();
    start0 = 0; start1 = 0;
    push_burst(0, 4, 12'h010, 8'hA0, 1'b1);
    run_traffic("burst4", 50, 0);
    check_order("burst4");
    check_span("burst4", 3);
    checks++;
    if (bus.owner !== 2'b00) $display("FAIL burst4_owner_after got=%b want=00", bus.owner);
    else passed++;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      start0 = 0; start1 = 0;
      push_burst(0, 2, 12'h100 + r * 16, 8'h10 + r * 16, 1'b1);
      push_burst(1, 2, 12'h200 + r * 16, 8'h20 + r * 16, 1'b1);
      run_traffic("round_robin", 50, 0);
      check_order("round_robin");
      check_span("round_robin", 3);
    end
  endtask

  task automatic test_preempt();
    do_reset();
    start0 = 0; start1 = 2;
    for (int i = 0; i < 4; i++) push_burst(0, 1, 12'h300 + i, 8'h30 + i, 1'b0);
    push_burst(1, 2, 12'h400, 8'h40, 1'b1);
    for (int i = 4; i < 10; i++) push_burst(0, 1, 12'h300 + i, 8'h30 + i, 1'b0);
    run_traffic("preempt", 80, 0);
    check_order("preempt");
    check_span("preempt", 11);
  endtask

  task automatic test_alone_cap();
    start0 = 0; start1 = 0;
    push_burst(0, 10, 12'h500, 8'h50, 1'b0);
    run_traffic("alone_cap", 80, 0);
    check_order("alone_cap");
    check_span("alone_cap", 9);
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    start0 = 0; start1 = 0;
    push_burst(1, 5, 12'h600, 8'h60, 1'b1);
    run_traffic("mid_reset", 50, 2);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.ack1 !== 1'b0 || bus.owner !== 2'b00 || bus.ram_write_enable !== 1'b0 ||
        bus.ram_address !== 12'h000 || bus.ram_data_out !== 8'h00)
      $display("FAIL mid_reset_outputs got ack1=%b owner=%b we=%b addr=%h data=%h want all 0",
               bus.ack1, bus.owner, bus.ram_write_enable, bus.ram_address, bus.ram_data_out);
    else passed++;
    q1.delete();
    sb.delete();
    exp_order.delete();
    bus.req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.ram_write_enable !== 1'b0 || bus.owner !== 2'b00)
        $display("FAIL mid_reset_after[%0d] got we=%b owner=%b want 0/00", i, bus.ram_write_enable, bus.owner);
      else passed++;
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0;
    bus.data0 = '0; bus.data1 = '0;
    bus.last0 = 1'b0; bus.last1 = 1'b0;
    test_reset();
    test_burst4();
    test_round_robin();
    test_preempt();
    test_alone_cap();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
